// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, port owner and access sizes.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, one transaction in flight.
// Define SRAM_ARB_RR_EN for round-robin tie-break instead of fixed data-over-inst priority.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic grant;
  logic sel_data;
  logic done;

  assign grant = (state == IDLE) & (inst_req | data_req);
  // mem_data_ok only counts once the address phase has been accepted
  assign done  = (((state == ADDR) & mem_addr_ok) | (state == WAIT)) & mem_data_ok;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  // On a tie the requester not served last time wins
  assign sel_data = data_req & (~inst_req | (last_grant == OWN_INST));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_DATA;
    end else if (grant) begin
      last_grant <= sel_data;
    end
  end
`else
  assign sel_data = data_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (inst_req | data_req) state_nxt = ADDR;
      ADDR: if (mem_addr_ok) state_nxt = mem_data_ok ? IDLE : WAIT;
      WAIT: if (mem_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    unique case (state)
      IDLE: begin
        inst_addr_ok = grant & ~sel_data;
        data_addr_ok = grant & sel_data;
      end
      ADDR: begin
        mem_req      = 1'b1;
        inst_data_ok = done & (owner == OWN_INST);
        data_data_ok = done & (owner == OWN_DATA);
      end
      WAIT: begin
        inst_data_ok = done & (owner == OWN_INST);
        data_data_ok = done & (owner == OWN_DATA);
      end
      default: ;
    endcase
  end

  // Winner's request is captured at grant and held for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner   <= sel_data;
      wr_q    <= sel_data ? data_wr    : inst_wr;
      size_q  <= sel_data ? data_size  : inst_size;
      addr_q  <= sel_data ? data_addr  : inst_addr;
      wdata_q <= sel_data ? data_wdata : inst_wdata;
    end
  end

  assign mem_wr     = wr_q;
  assign mem_size   = size_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending request record, address-phase flag, completion
  logic        started = 1'b0;
  logic        m_active = 1'b0, m_acc = 1'b0, m_owner = 1'b0;
  logic        m_wr = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = '0, m_wdata = '0;
`ifdef SRAM_ARB_RR_EN
  logic        m_last = 1'b1;
`endif

  always @(negedge clk) begin
    logic e_iao, e_dao, e_ido, e_ddo, e_mreq, win_data, done;
    e_iao = 0; e_dao = 0; e_ido = 0; e_ddo = 0; e_mreq = 0; done = 0; win_data = 0;
    if (!m_active) begin
      if (inst_req || data_req) begin
`ifdef SRAM_ARB_RR_EN
        win_data = (inst_req && data_req) ? !m_last : data_req;
        m_last   = win_data;
`else
        win_data = data_req;
`endif
        e_dao = win_data; e_iao = !win_data;
        m_active = 1; m_acc = 0; m_owner = win_data;
        m_wr    = win_data ? data_wr    : inst_wr;
        m_size  = win_data ? data_size  : inst_size;
        m_addr  = win_data ? data_addr  : inst_addr;
        m_wdata = win_data ? data_wdata : inst_wdata;
      end
    end else if (!m_acc) begin
      e_mreq = 1;
      if (started) begin
        chk("m_mem_wr", mem_wr, m_wr);
        chk("m_mem_size", mem_size, m_size);
        chk("m_mem_addr", mem_addr, m_addr);
        chk("m_mem_wdata", mem_wdata, m_wdata);
      end
      if (mem_addr_ok) begin
        if (mem_data_ok) done = 1; else m_acc = 1;
      end
    end else if (mem_data_ok) begin
      done = 1;
    end
    if (done) begin
      e_ddo = m_owner; e_ido = !m_owner; m_active = 0;
    end
    if (started) begin
      chk("m_inst_addr_ok", inst_addr_ok, e_iao);
      chk("m_data_addr_ok", data_addr_ok, e_dao);
      chk("m_inst_data_ok", inst_data_ok, e_ido);
      chk("m_data_data_ok", data_data_ok, e_ddo);
      chk("m_mem_req", mem_req, e_mreq);
      if (e_ido) chk("m_inst_rdata", inst_rdata, mem_rdata);
      if (e_ddo) chk("m_data_rdata", data_rdata, mem_rdata);
    end
    if (rst) begin
      m_active = 0; m_acc = 0; started = 1;
`ifdef SRAM_ARB_RR_EN
      m_last = 1'b1;
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Address phase accepted, then data returned one cycle later
  task automatic serve(input logic own_data, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] rd);
    mem_addr_ok = 1;
    @(negedge clk);
    chk("sv_mem_req", mem_req, 1);
    chk("sv_mem_wr", mem_wr, exp_wr);
    chk("sv_mem_addr", mem_addr, exp_addr);
    chk("sv_mem_wdata", mem_wdata, exp_wdata);
    chk("sv_no_aok", {inst_addr_ok, data_addr_ok}, 0);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = rd;
    @(negedge clk);
    chk("sv_owner_dok", own_data ? data_data_ok : inst_data_ok, 1);
    chk("sv_other_dok", own_data ? inst_data_ok : data_data_ok, 0);
    chk("sv_rdata", own_data ? data_rdata : inst_rdata, rd);
    next_cycle();
    mem_data_ok = 0;
  endtask

  initial begin
    logic first_data;
    rst = 1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state, and mem_data_ok ignored in IDLE
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_aok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_dok", {inst_data_ok, data_data_ok}, 0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("idle_dok_ignored", {inst_data_ok, data_data_ok}, 0);
    next_cycle();
    mem_data_ok = 0;

    // 1: fetch only
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    @(negedge clk);
    chk("t1_inst_aok", inst_addr_ok, 1);
    chk("t1_data_aok", data_addr_ok, 0);
    chk("t1_mem_req_c0", mem_req, 0);
    next_cycle();
    inst_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("t1_mem_req_c1", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("t1_mem_size", mem_size, 2);
    next_cycle();
    mem_addr_ok = 0;
    @(negedge clk);
    chk("t1_mem_req_c2", mem_req, 0);
    chk("t1_dok_c2", inst_data_ok, 0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h3C08_BFAF;
    @(negedge clk);
    chk("t1_inst_dok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C08_BFAF);
    chk("t1_data_dok", data_data_ok, 0);
    next_cycle();
    mem_data_ok = 0;

    // 2: simultaneous requests from a fresh reset
    rst = 1;
    next_cycle();
    rst = 0;
`ifdef SRAM_ARB_RR_EN
    first_data = 0;
`else
    first_data = 1;
`endif
    inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC0_0004; inst_wdata = 0; inst_size = 2'd2;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; data_size = 2'd2;
    @(negedge clk);
    chk("t2_first_data_aok", data_addr_ok, first_data);
    chk("t2_first_inst_aok", inst_addr_ok, !first_data);
    next_cycle();
    if (first_data) data_req = 0; else inst_req = 0;
    if (first_data) serve(1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0);
    else            serve(0, 0, 32'hBFC0_0004, 32'h0, 32'h2402_0001);
    @(negedge clk);
    chk("t2_second_data_aok", data_addr_ok, !first_data);
    chk("t2_second_inst_aok", inst_addr_ok, first_data);
    next_cycle();
    inst_req = 0; data_req = 0;
    if (first_data) serve(0, 0, 32'hBFC0_0004, 32'h0, 32'h2402_0001);
    else            serve(1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0);

    // 3: address stall while the requester changes its inputs
    data_req = 1; data_wr = 1; data_addr = 32'h8000_2000; data_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("t3_aok", data_addr_ok, 1);
    next_cycle();
    data_req = 0; data_addr = 32'h0; data_wdata = 32'hFFFF_FFFF; data_wr = 0; data_size = 2'd0;
    for (int i = 0; i < 5; i++) begin
      mem_data_ok = (i == 2);
      @(negedge clk);
      chk("t3_stall_req", mem_req, 1);
      chk("t3_stall_addr", mem_addr, 32'h8000_2000);
      chk("t3_stall_wdata", mem_wdata, 32'h1122_3344);
      chk("t3_stall_dok", data_data_ok, 0);
      next_cycle();
    end
    mem_data_ok = 0;
    serve(1, 1, 32'h8000_2000, 32'h1122_3344, 32'h0);

    // 4: same-cycle accept and completion, new grant next cycle
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    @(negedge clk);
    chk("t4_inst_aok", inst_addr_ok, 1);
    next_cycle();
    inst_req = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0040; data_wdata = 0; data_size = 2'd2;
    @(negedge clk);
    chk("t4_inst_dok", inst_data_ok, 1);
    chk("t4_inst_rdata", inst_rdata, 32'h1234_5678);
    chk("t4_data_aok_busy", data_addr_ok, 0);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 0;
    @(negedge clk);
    chk("t4_regrant", data_addr_ok, 1);
    chk("t4_mem_req_idle", mem_req, 0);
    next_cycle();
    data_req = 0;
    serve(1, 0, 32'h8000_0040, 32'h0, 32'hCAFE_F00D);

    // 5: reset while waiting for data
    data_req = 1; data_addr = 32'h8000_0080;
    @(negedge clk);
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("t5_mem_req", mem_req, 1);
    next_cycle();
    mem_addr_ok = 0; rst = 1;
    @(negedge clk);
    chk("t5_dok_in_rst", data_data_ok, 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("t5_mem_req_after", mem_req, 0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("t5_late_dok", {inst_data_ok, data_data_ok}, 0);
    chk("t5_late_mem_req", mem_req, 0);
    next_cycle();
    mem_data_ok = 0;

    // 6: byte load passes size/address/rdata untouched
    data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h8000_0003;
    @(negedge clk);
    chk("t6_aok", data_addr_ok, 1);
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("t6_mem_size", mem_size, 0);
    chk("t6_mem_addr", mem_addr, 32'h8000_0003);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hA5B6_C7D8;
    @(negedge clk);
    chk("t6_dok", data_data_ok, 1);
    chk("t6_rdata", data_rdata, 32'hA5B6_C7D8);
    next_cycle();
    mem_data_ok = 0;

    repeat (2) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
